// File: rtl/stack_call_ctrl_pkg.sv
// Shared types for the call/return sequencer: command encodings, FSM states,
// and the bundle of stack control pulses.
// Pure declarations; no timing or flow control here.
package stack_ctrl_pkg;

  localparam int DW_DEF = 4;

  typedef enum logic [2:0] {
    OP_STEP = 3'd0,
    OP_CALL = 3'd1,
    OP_RET  = 3'd2,
    OP_PUSH = 3'd3,
    OP_POP  = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    PUSH,
    POP_DEC,
    POP_RD
  } state_e;

  // Control pulses towards the stack, registered as one bundle.
  typedef struct packed {
    logic rst;
    logic push;
    logic pop;
    logic we;
    logic re;
    logic mux_sel;
  } stk_ctl_t;

  // Unassigned encodings 5-7 behave as STEP.
  function automatic op_e decode_op(input logic [2:0] raw);
    op_e op;
    case (raw)
      3'd1:    op = OP_CALL;
      3'd2:    op = OP_RET;
      3'd3:    op = OP_PUSH;
      3'd4:    op = OP_POP;
      default: op = OP_STEP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/stack_call_ctrl_if.sv
// Command channel into the sequencer: strobe, opcode and argument.
// Accepted on a cycle where cmd_valid && cmd_ready; no queuing.
// Issuer must hold or re-present the command while cmd_ready is low.
// Ports: cmd_valid, cmd_op, cmd_arg (issuer -> sequencer), cmd_ready (back).
interface stack_call_ctrl_if #(
  parameter int DW = 4
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/stack_call_ctrl_fsm.sv
// Sequencer FSM: accepts commands in IDLE and emits registered stack pulses.
// Latency: pulses appear the cycle after acceptance; PUSH 1 busy cycle, pops 2.
// Backpressure: cmd_ready is high only in IDLE; commands offered otherwise are ignored.
// Ports: cmd_valid/cmd_op in, cmd_ready out, stk_full/stk_empty in, ctl pulses
// out, ev_* single-cycle accept strobes and rd_done (last cycle of a pop) out.
module stack_ctrl_fsm
  import stack_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     cmd_valid,
  input  logic [2:0] cmd_op,
  input  logic     stk_full,
  input  logic     stk_empty,
  output logic     cmd_ready,
  output stk_ctl_t ctl,
  output logic     ev_step,
  output logic     ev_call,
  output logic     ev_push,
  output logic     ev_ret,
  output logic     ev_pop,
  output logic     ev_ovf,
  output logic     ev_udf,
  output logic     rd_done
);

  state_e   state, state_nxt;
  stk_ctl_t ctl_nxt;
  op_e      op;
  logic     accept, is_wr, is_rd;

  assign op        = decode_op(cmd_op);
  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign is_wr     = (op == OP_CALL) || (op == OP_PUSH);
  assign is_rd     = (op == OP_RET)  || (op == OP_POP);

  // State register; pulse bundle is registered alongside so every stk_*
  // output comes straight from a flop. Reset holds the stack in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_HOLD;
      ctl   <= '{rst: 1'b1, default: 1'b0};
    end else begin
      state <= state_nxt;
      ctl   <= ctl_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RST_HOLD: state_nxt = IDLE;
      IDLE: begin
        if (accept && is_wr && !stk_full)  state_nxt = PUSH;
        if (accept && is_rd && !stk_empty) state_nxt = POP_DEC;
      end
      PUSH:    state_nxt = IDLE;
      POP_DEC: state_nxt = POP_RD;
      POP_RD:  state_nxt = IDLE;
      default: state_nxt = RST_HOLD;
    endcase
  end

  // Pulses for the upcoming cycle are decoded from the state being entered.
  always_comb begin
    ctl_nxt     = '0;
    ctl_nxt.rst = (state_nxt == RST_HOLD);
    case (state_nxt)
      PUSH: begin
        ctl_nxt.push    = 1'b1;
        ctl_nxt.we      = 1'b1;
        ctl_nxt.mux_sel = (op == OP_PUSH);
      end
      POP_DEC: ctl_nxt.pop = 1'b1;
      POP_RD:  ctl_nxt.re  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ev_step = accept && (op == OP_STEP);
    ev_call = accept && (op == OP_CALL) && !stk_full;
    ev_push = accept && (op == OP_PUSH) && !stk_full;
    ev_ret  = accept && (op == OP_RET)  && !stk_empty;
    ev_pop  = accept && (op == OP_POP)  && !stk_empty;
    ev_ovf  = accept && is_wr && stk_full;
    ev_udf  = accept && is_rd && stk_empty;
    rd_done = (state == POP_RD);
  end

endmodule

// File: rtl/stack_call_ctrl.sv
// Call/return sequencer driving a LIFO stack: holds the PC, pop data and sticky errors.
// Latency: STEP/CALL/PUSH 1 cycle, RET/POP 3 cycles to result (2 busy cycles).
// Backpressure: cmd.cmd_ready low while busy or in reset hold; no command queuing.
// Ports: clk, rst_n, cmd (command channel), err_clr; pc, pop_data/pop_valid,
// ovf/udf; stk_* controls and data towards the stack, stk_data_i/full/empty back.
module stack_call_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  stack_call_ctrl_if.slave cmd,
  input  logic          err_clr,
  output logic [DW-1:0] pc,
  output logic [DW-1:0] pop_data,
  output logic          pop_valid,
  output logic          ovf,
  output logic          udf,
  output logic          stk_reset,
  output logic          stk_push,
  output logic          stk_pop,
  output logic          stk_we,
  output logic          stk_re,
  output logic          stk_mux_sel,
  output logic [DW-1:0] stk_data_o,
  output logic [DW-1:0] stk_pc_o,
  input  logic [DW-1:0] stk_data_i,
  input  logic          stk_full,
  input  logic          stk_empty
);

  localparam int unsigned DEPTH_U = DEPTH;

  stk_ctl_t ctl;
  logic ev_step, ev_call, ev_push, ev_ret, ev_pop, ev_ovf, ev_udf, rd_done;
  logic ret_pend;  // distinguishes RET from POP during the read cycle

  stack_ctrl_fsm u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd.cmd_valid),
    .cmd_op    (cmd.cmd_op),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .cmd_ready (cmd.cmd_ready),
    .ctl       (ctl),
    .ev_step   (ev_step),
    .ev_call   (ev_call),
    .ev_push   (ev_push),
    .ev_ret    (ev_ret),
    .ev_pop    (ev_pop),
    .ev_ovf    (ev_ovf),
    .ev_udf    (ev_udf),
    .rd_done   (rd_done)
  );

  assign stk_reset   = ctl.rst;
  assign stk_push    = ctl.push;
  assign stk_pop     = ctl.pop;
  assign stk_we      = ctl.we;
  assign stk_re      = ctl.re;
  assign stk_mux_sel = ctl.mux_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      pop_data   <= '0;
      pop_valid  <= 1'b0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
      ret_pend   <= 1'b0;
      stk_data_o <= '0;
      stk_pc_o   <= '0;
    end else begin
      if (ev_step)          pc <= pc + 1'b1;
      if (ev_call)          pc <= cmd.cmd_arg;
      if (rd_done && ret_pend) pc <= stk_data_i;

      // Return address is the instruction after the CALL.
      if (ev_call) stk_pc_o   <= pc + 1'b1;
      if (ev_push) stk_data_o <= cmd.cmd_arg;

      if (ev_ret) ret_pend <= 1'b1;
      if (ev_pop) ret_pend <= 1'b0;

      pop_valid <= rd_done && !ret_pend;
      if (rd_done && !ret_pend) pop_data <= stk_data_i;

      // A new error beats a simultaneous clear.
      ovf <= ev_ovf || (ovf && !err_clr);
      udf <= ev_udf || (udf && !err_clr);
    end
  end

  // Shadow occupancy used only to sanity-check the pulse stream.
  int unsigned occ;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    occ <= 0;
    else if (stk_reset)            occ <= 0;
    else if (stk_push)             occ <= occ + 32'd1;
    else if (stk_pop && occ != 0)  occ <= occ - 32'd1;
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    !(stk_push && stk_pop) && (!stk_we || stk_push) && (occ <= DEPTH_U));

endmodule

// File: tb/tb_stack_call_ctrl.sv
module tb_stack_call_ctrl;
  import stack_ctrl_pkg::*;

  typedef struct packed {
    logic       push;
    logic       pop;
    logic       we;
    logic       re;
    logic       mux_sel;
    logic [3:0] val;
  } pulse_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       err_clr = 1'b0;
  logic [3:0] pc, pop_data, stk_data_o, stk_pc_o, stk_data_i;
  logic       pop_valid, ovf, udf;
  logic       stk_reset, stk_push, stk_pop, stk_we, stk_re, stk_mux_sel;
  logic       stk_full, stk_empty;

  int checks = 0;
  int errors = 0;

  pulse_t     exp_pulse_q[$];
  logic [3:0] exp_pop_q[$];

  always #5 clk = ~clk;

  stack_call_ctrl_if #(.DW(4)) cif ();

  stack_call_ctrl #(.DW(4), .DEPTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cif),
    .err_clr     (err_clr),
    .pc          (pc),
    .pop_data    (pop_data),
    .pop_valid   (pop_valid),
    .ovf         (ovf),
    .udf         (udf),
    .stk_reset   (stk_reset),
    .stk_push    (stk_push),
    .stk_pop     (stk_pop),
    .stk_we      (stk_we),
    .stk_re      (stk_re),
    .stk_mux_sel (stk_mux_sel),
    .stk_data_o  (stk_data_o),
    .stk_pc_o    (stk_pc_o),
    .stk_data_i  (stk_data_i),
    .stk_full    (stk_full),
    .stk_empty   (stk_empty)
  );

  // Behavioural 16-entry LIFO standing in for the real stack.
  logic [3:0] mem [16];
  logic [4:0] sp;
  always @(posedge clk) begin
    if (stk_reset) sp <= 5'd0;
    else if (stk_push && stk_we) begin
      mem[sp[3:0]] <= stk_mux_sel ? stk_data_o : stk_pc_o;
      sp <= sp + 5'd1;
    end else if (stk_pop && sp != 5'd0) sp <= sp - 5'd1;
  end
  assign stk_full   = (sp == 5'd16);
  assign stk_empty  = (sp == 5'd0);
  assign stk_data_i = stk_re ? mem[sp[3:0]] : 4'h0;

  function automatic pulse_t mk(input logic pu, input logic po, input logic w,
                                input logic r, input logic m, input logic [3:0] v);
    pulse_t p;
    p.push = pu; p.pop = po; p.we = w; p.re = r; p.mux_sel = m; p.val = v;
    return p;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every stack pulse and every pop_valid is matched against the queues.
  always @(negedge clk) begin
    pulse_t act, e;
    if (rst_n) begin
      act = mk(stk_push, stk_pop, stk_we, stk_re, stk_mux_sel,
               stk_push ? (stk_mux_sel ? stk_data_o : stk_pc_o) : 4'h0);
      if (stk_push || stk_pop || stk_we || stk_re || stk_mux_sel) begin
        checks++;
        if (exp_pulse_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got %h expected none", act);
        end else begin
          e = exp_pulse_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL pulse: got %h expected %h", act, e);
          end
        end
      end
      if (pop_valid) begin
        checks++;
        if (exp_pop_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pop_valid: got data %h expected none", pop_data);
        end else begin
          logic [3:0] d;
          d = exp_pop_q.pop_front();
          if (pop_data !== d) begin
            errors++;
            $display("FAIL pop_data: got %h expected %h", pop_data, d);
          end
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!cif.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cif.cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: got 0 expected 1", name);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] arg);
    @(negedge clk);
    wait_ready("issue");
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_arg   = arg;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    wait_ready("done");
  endtask

  task automatic exp_wr(input logic m, input logic [3:0] v);
    exp_pulse_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, m, v));
  endtask

  task automatic exp_rd();
    exp_pulse_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0));
    exp_pulse_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 3'd0;
    cif.cmd_arg   = 4'h0;

    // Reset and release
    repeat (3) @(negedge clk);
    chk("rst_stk_reset", stk_reset, 1);
    chk("rst_ready", cif.cmd_ready, 0);
    chk("rst_pc", pc, 0);
    chk("rst_errs", {ovf, udf, pop_valid}, 0);
    rst_n = 1'b1;
    #1 chk("hold_stk_reset", stk_reset, 1);
    chk("hold_ready", cif.cmd_ready, 0);
    @(negedge clk);
    chk("idle_ready", cif.cmd_ready, 1);
    chk("idle_stk_reset", stk_reset, 0);
    chk("idle_empty", stk_empty, 1);

    // STEP wrap: 16 steps back to 0, one more to 1
    for (int i = 0; i < 16; i++) issue(OP_STEP, 4'h0);
    chk("step16_pc", pc, 0);
    issue(OP_STEP, 4'h0);
    chk("step17_pc", pc, 1);
    issue(3'd6, 4'hF);  // undefined opcode acts as STEP
    chk("op6_pc", pc, 2);
    issue(OP_STEP, 4'h0);
    chk("pc3", pc, 3);

    // CALL 9 from pc=3 pushes return address 4
    exp_wr(1'b0, 4'd4);
    issue(OP_CALL, 4'd9);
    chk("call_pc", pc, 9);
    exp_rd();
    issue(OP_RET, 4'h0);
    chk("ret_pc", pc, 4);
    chk("ret_empty", stk_empty, 1);

    // Data push/pop ordering
    exp_wr(1'b1, 4'hA);
    issue(OP_PUSH, 4'hA);
    exp_wr(1'b1, 4'h5);
    issue(OP_PUSH, 4'h5);
    exp_rd(); exp_pop_q.push_back(4'h5);
    issue(OP_POP, 4'h0);
    exp_rd(); exp_pop_q.push_back(4'hA);
    issue(OP_POP, 4'h0);
    @(negedge clk);
    chk("pp_empty", stk_empty, 1);
    chk("pp_pc", pc, 4);

    // Fill, overflow, clear, overflow with clear held
    for (int i = 0; i < 16; i++) begin
      exp_wr(1'b1, 4'(i));
      issue(OP_PUSH, 4'(i));
    end
    chk("full", stk_full, 1);
    issue(OP_CALL, 4'd7);
    chk("ovf_set", ovf, 1);
    chk("ovf_pc", pc, 4);
    @(negedge clk) err_clr = 1'b1;
    @(negedge clk) err_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    err_clr = 1'b1;
    issue(OP_PUSH, 4'd1);
    err_clr = 1'b0;
    chk("ovf_beats_clr", ovf, 1);
    chk("ovf_udf", udf, 0);
    for (int i = 15; i >= 0; i--) begin
      exp_rd(); exp_pop_q.push_back(4'(i));
      issue(OP_POP, 4'h0);
    end
    chk("drain_empty", stk_empty, 1);
    issue(OP_RET, 4'h0);
    chk("udf_set", udf, 1);
    chk("udf_pc", pc, 4);

    // Reset asserted during the read cycle of a POP
    exp_wr(1'b1, 4'h3);
    issue(OP_PUSH, 4'h3);
    exp_rd();
    @(negedge clk);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = OP_POP;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    for (int n = 0; n < 5 && !stk_re; n++) @(negedge clk);
    chk("mid_re_seen", stk_re, 1);
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_re", stk_re, 0);
    chk("mid_rst_reset", stk_reset, 1);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_flags", {ovf, udf, pop_valid, cif.cmd_ready}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_empty", stk_empty, 1);
    chk("post_rst_ready", cif.cmd_ready, 1);
    repeat (3) @(negedge clk);

    chk("pulse_q_drained", exp_pulse_q.size(), 0);
    chk("pop_q_drained", exp_pop_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
